// File: rtl/polylut_argmax.sv
// polylut_argmax: result stage behind polylut.
// Delays in_valid to line up with M2, buffers M2 words in a small FIFO and
// scans the packed signed class scores one per cycle to find the argmax.
// Optional feature macro: POLYLUT_ARGMAX_MARGIN_EN adds out_margin, the gap
// between the winning score and the runner-up score.
module polylut_argmax #(
    parameter int NUM_CLASSES = 5,
    parameter int SCORE_W     = 4,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [NUM_CLASSES*SCORE_W-1:0]     M2,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(NUM_CLASSES)-1:0]     out_class,
    output logic                               overflow,
    output logic                               busy
`ifdef POLYLUT_ARGMAX_MARGIN_EN
    ,
    output logic [SCORE_W:0]                   out_margin
`endif
);

    localparam int DATA_W = NUM_CLASSES * SCORE_W;
    localparam int IDX_W  = $clog2(NUM_CLASSES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                    state;
    logic [LATENCY-1:0]        vld_pipe;
    logic                      vld_d;

    logic [DATA_W-1:0]         mem [FIFO_DEPTH];
    logic [PTR_W:0]            wr_ptr;
    logic [PTR_W:0]            rd_ptr;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_drop;
    logic [DATA_W-1:0]         head;

    logic [DATA_W-1:0]         score_r;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          best_idx;
    logic signed [SCORE_W-1:0] best;
    logic signed [SCORE_W-1:0] cur_score;
    logic                      cand_gt;
    logic                      last_idx;
    logic signed [SCORE_W-1:0] next_best;
    logic [IDX_W-1:0]          next_idx;

`ifdef POLYLUT_ARGMAX_MARGIN_EN
    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
    logic signed [SCORE_W-1:0] second;
    logic signed [SCORE_W-1:0] next_second;
    logic [SCORE_W:0]          margin_calc;
`endif

    // Shift in_valid through LATENCY flops so vld_d lines up with a valid M2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign vld_d = vld_pipe[LATENCY-1];

    // FIFO status; the extra pointer bit tells full from empty
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head       = mem[rd_ptr[PTR_W-1:0]];

    // The scanner takes a word when idle, or when its result is handed off
    assign fifo_pop  = !fifo_empty &&
                       ((state == IDLE) || ((state == DONE) && out_ready));
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign fifo_push = vld_d && (!fifo_full || fifo_pop);
    assign fifo_drop = vld_d && fifo_full && !fifo_pop;

    // FIFO storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= M2;
        end
    end

    // FIFO pointers and the sticky drop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            if (fifo_drop) overflow <= 1'b1;
        end
    end

    // Compare the current class score against the running best
    always_comb begin
        cur_score = $signed(score_r[int'(idx)*SCORE_W +: SCORE_W]);
        cand_gt   = (cur_score > best);
        next_best = cand_gt ? cur_score : best;
        next_idx  = cand_gt ? idx : best_idx;
        last_idx  = (idx == IDX_W'(NUM_CLASSES-1));
`ifdef POLYLUT_ARGMAX_MARGIN_EN
        if (cand_gt) begin
            next_second = best;
        end else if (cur_score > second) begin
            next_second = cur_score;
        end else begin
            next_second = second;
        end
        margin_calc = {next_best[SCORE_W-1], next_best} -
                      {next_second[SCORE_W-1], next_second};
`endif
    end

    // Scan FSM: load a word, walk the classes, then hold the result until taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            score_r   <= '0;
            idx       <= '0;
            best      <= '0;
            best_idx  <= '0;
            out_valid <= 1'b0;
            out_class <= '0;
`ifdef POLYLUT_ARGMAX_MARGIN_EN
            second     <= '0;
            out_margin <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                end
                SCAN: begin
                    best     <= next_best;
                    best_idx <= next_idx;
`ifdef POLYLUT_ARGMAX_MARGIN_EN
                    second   <= next_second;
`endif
                    if (last_idx) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_class <= next_idx;
`ifdef POLYLUT_ARGMAX_MARGIN_EN
                        out_margin <= margin_calc;
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (fifo_pop) begin
                score_r  <= head;
                best     <= $signed(head[SCORE_W-1:0]);
                best_idx <= '0;
                idx      <= IDX_W'(1);
                state    <= SCAN;
`ifdef POLYLUT_ARGMAX_MARGIN_EN
                second   <= SCORE_MIN;
`endif
            end
        end
    end

    assign busy = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_polylut_argmax.sv
// Testbench for polylut_argmax.
// A two-register stand-in for polylut feeds M2; results are checked against
// a plain argmax model kept in a queue of expected results.
module tb_polylut_argmax;

    localparam int NUM_CLASSES = 5;
    localparam int SCORE_W     = 4;
    localparam int DATA_W      = NUM_CLASSES * SCORE_W;
    localparam int IDX_W       = $clog2(NUM_CLASSES);

    typedef struct {
        int cls;
        int margin;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] M2;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_class;
    logic              overflow;
    logic              busy;
`ifdef POLYLUT_ARGMAX_MARGIN_EN
    logic [SCORE_W:0]  out_margin;
`endif

    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] m2_p1;

    exp_t expQ[$];
    int   checkCount;
    int   passCount;

    polylut_argmax #(
        .NUM_CLASSES(NUM_CLASSES),
        .SCORE_W(SCORE_W),
        .LATENCY(2),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .M2(M2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .overflow(overflow),
        .busy(busy)
`ifdef POLYLUT_ARGMAX_MARGIN_EN
        ,
        .out_margin(out_margin)
`endif
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for polylut: M2 appears two registers after the sample
    always @(posedge clk) begin
        m2_p1 <= sample_data;
        M2    <= m2_p1;
    end

    // Count one comparison and report it when it misses
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Argmax reference: first maximum wins, margin is best minus best of the rest
    function automatic exp_t refArgmax(input logic [DATA_W-1:0] v);
        int   s[NUM_CLASSES];
        int   bestVal;
        int   secondVal;
        exp_t r;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            s[i] = int'(v[SCORE_W*i +: SCORE_W]);
            if (s[i] >= (1 << (SCORE_W-1))) s[i] = s[i] - (1 << SCORE_W);
        end
        bestVal = -1000;
        r.cls   = 0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (s[i] > bestVal) begin
                bestVal = s[i];
                r.cls   = i;
            end
        end
        secondVal = -1000;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (i != r.cls && s[i] > secondVal) secondVal = s[i];
        end
        r.margin = bestVal - secondVal;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for one cycle; queue its expected result unless dropped
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input bit expectDrop);
        sample_data = data;
        in_valid    = 1'b1;
        if (!expectDrop) expQ.push_back(refArgmax(data));
        tick();
        in_valid = 1'b0;
    endtask

    // Wait, with a cycle budget, for every expected result to be consumed
    task automatic waitDrain(input string tag, input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, expQ.size(), 0);
        tick();
    endtask

    // Score every handshake against the head of the expected queue
    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("out_class", 32'(out_class), e.cls);
`ifdef POLYLUT_ARGMAX_MARGIN_EN
                checkOutput("out_margin", 32'(out_margin), e.margin);
`endif
            end
        end
    end

    initial begin
        int gap;
        logic [IDX_W-1:0] heldClass;

        checkCount  = 0;
        passCount   = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        sample_data = '0;
        M2          = '0;
        m2_p1       = '0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_class", 32'(out_class), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        tick();

        // Single sample: out_valid must rise exactly 7 edges after sampling
        applyStimulus(20'h3_7_2_5_1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) checkOutput("latency_early", 32'(out_valid), 0);
            if (k == 7) checkOutput("latency_rise", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        waitDrain("drain_single", 20);

        // Ties and negative extremes
        applyStimulus(20'h3_7_2_7_1, 1'b0);
        waitDrain("drain_tie", 20);
        applyStimulus(20'h8_8_8_8_9, 1'b0);
        waitDrain("drain_neg", 20);
        applyStimulus(20'h5_5_5_5_5, 1'b0);
        waitDrain("drain_equal", 20);
        applyStimulus(20'h7_8_8_8_8, 1'b0);
        waitDrain("drain_wide", 20);

        // Back-to-back at the steady-state rate
        for (int s = 0; s < 4; s++) begin
            applyStimulus(DATA_W'($urandom), 1'b0);
            for (int k = 0; k < 4; k++) tick();
        end
        waitDrain("drain_b2b", 40);
        checkOutput("b2b_overflow", 32'(overflow), 0);
        checkOutput("b2b_busy", 32'(busy), 0);

        // Random samples, consumer always ready
        for (int s = 0; s < 20; s++) begin
            applyStimulus(DATA_W'($urandom), 1'b0);
            gap = $urandom_range(5, 8);
            for (int k = 0; k < gap; k++) tick();
        end
        waitDrain("drain_rand", 40);

        // Random samples with a hesitant consumer
        for (int s = 0; s < 10; s++) begin
            applyStimulus(DATA_W'($urandom), 1'b0);
            for (int k = 0; k < 24; k++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        out_ready = 1'b1;
        waitDrain("drain_rand_stall", 60);
        checkOutput("rand_overflow", 32'(overflow), 0);

        // Backpressure: scanner plus two FIFO slots hold three samples, rest drop
        out_ready = 1'b0;
        applyStimulus(20'h1_2_3_4_7, 1'b0);
        applyStimulus(20'h6_1_1_1_1, 1'b0);
        applyStimulus(20'h1_1_5_1_1, 1'b0);
        applyStimulus(20'h1_7_1_1_1, 1'b1);
        applyStimulus(20'h7_1_1_1_1, 1'b1);
        gap = 0;
        while (!out_valid && gap < 20) begin
            tick();
            gap++;
        end
        checkOutput("bp_valid", 32'(out_valid), 1);
        heldClass = out_class;
        checkOutput("bp_first_class", 32'(heldClass), expQ[0].cls);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("bp_stable", 32'(out_class), 32'(heldClass));
        end
        checkOutput("bp_overflow", 32'(overflow), 1);
        out_ready = 1'b1;
        waitDrain("drain_bp", 40);
        checkOutput("bp_busy", 32'(busy), 0);

        // Reset in the middle of a scan drops everything
        applyStimulus(20'h2_6_3_1_4, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        #2;
        rst = 1'b0;
        expQ.delete();
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 0);
        checkOutput("mid_rst_out_class", 32'(out_class), 0);
        checkOutput("mid_rst_overflow", 32'(overflow), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        checkOutput("post_rst_busy", 32'(busy), 0);
        applyStimulus(20'h4_2_6_1_3, 1'b0);
        waitDrain("drain_post_rst", 20);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
